// File: rtl/nn_pkg.sv
// Shared definitions for the neural-network datapath blocks.
// Holds the argmax FSM state encoding and the default lane width.
package nn_pkg;

   typedef enum logic [1:0] {ST_COLLECT, ST_SCAN, ST_DONE} argmax_state_t;

   localparam int DATA_WIDTH_DEF = 16;

endpackage

// File: rtl/layer_argmax.sv
// Classification tail: captures one value per output neuron, then scans the
// captured lanes one per cycle and reports the signed maximum and its index.
module layer_argmax
   import nn_pkg::*;
#(
   parameter  int NUM_NEURON = 10,
   parameter  int DATA_WIDTH = DATA_WIDTH_DEF,
   localparam int IDX_WIDTH  = $clog2(NUM_NEURON)
) (
   input  logic                             i_clk,
   input  logic                             i_reset,
   input  logic [NUM_NEURON*DATA_WIDTH-1:0] i_input,
   input  logic [NUM_NEURON-1:0]            i_input_valid,
   output logic                             o_busy,
   output logic [IDX_WIDTH-1:0]             o_max_index,
   output logic [DATA_WIDTH-1:0]            o_max_value,
   output logic                             o_valid,
   output logic                             o_overrun
);

   // Interface: i_input_valid[k] is a 1-cycle qualifier for lane k with no
   // ready; pulses outside COLLECT are dropped and flagged on o_overrun.
   // o_valid is a 1-cycle result strobe; o_max_* hold until the next strobe.

   argmax_state_t state, state_next;

   logic [NUM_NEURON-1:0] flag;
   logic [DATA_WIDTH-1:0] lane_reg [NUM_NEURON];
   logic [DATA_WIDTH-1:0] lane_in  [NUM_NEURON];
   logic [DATA_WIDTH-1:0] best_val;
   logic [IDX_WIDTH-1:0]  best_idx;
   logic [IDX_WIDTH-1:0]  cnt;
   logic [DATA_WIDTH-1:0] cur_val;
   logic                  all_in;
   logic                  last;
   logic                  gt;

   always_comb begin
      for (int k = 0; k < NUM_NEURON; k++) begin
         lane_in[k] = i_input[k*DATA_WIDTH +: DATA_WIDTH];
      end
   end

   // Single comparator, fed by a cnt-selected lane.
   always_comb begin
      cur_val = '0;
      for (int k = 0; k < NUM_NEURON; k++) begin
         if (cnt == IDX_WIDTH'(k)) cur_val = lane_reg[k];
      end
   end

   assign all_in = &(flag | i_input_valid);
   assign last   = (cnt == IDX_WIDTH'(NUM_NEURON - 1));
   assign gt     = ($signed(cur_val) > $signed(best_val));

   always_ff @(posedge i_clk) begin
      if (i_reset) state <= ST_COLLECT;
      else         state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         ST_COLLECT: if (all_in) state_next = ST_SCAN;
         ST_SCAN:    if (last)   state_next = ST_DONE;
         ST_DONE:    state_next = ST_COLLECT;
         default:    state_next = ST_COLLECT;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         flag        <= '0;
         best_val    <= '0;
         best_idx    <= '0;
         cnt         <= '0;
         o_max_index <= '0;
         o_max_value <= '0;
         o_overrun   <= 1'b0;
         for (int k = 0; k < NUM_NEURON; k++) lane_reg[k] <= '0;
      end else begin
         o_overrun <= (state != ST_COLLECT) && (|i_input_valid);
         case (state)
            ST_COLLECT: begin
               for (int k = 0; k < NUM_NEURON; k++) begin
                  if (i_input_valid[k]) lane_reg[k] <= lane_in[k];
               end
               flag <= flag | i_input_valid;
               if (all_in) begin
                  best_val <= i_input_valid[0] ? lane_in[0] : lane_reg[0];
                  best_idx <= '0;
                  cnt      <= IDX_WIDTH'(1);
               end
            end
            ST_SCAN: begin
               if (gt) begin
                  best_val <= cur_val;
                  best_idx <= cnt;
               end
               // Publish on the last compare so the result is already stable in DONE.
               if (last) begin
                  o_max_value <= gt ? cur_val : best_val;
                  o_max_index <= gt ? cnt : best_idx;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            ST_DONE: begin
               flag <= '0;
               cnt  <= '0;
            end
            default: begin
               flag <= '0;
               cnt  <= '0;
            end
         endcase
      end
   end

   assign o_busy  = (state != ST_COLLECT);
   assign o_valid = (state == ST_DONE);

endmodule

// File: tb/tb_layer_argmax.sv
// Directed bench for layer_argmax with NUM_NEURON=10, DATA_WIDTH=16.
// Expected indices and values are hand-computed per frame.
module tb_layer_argmax;

   localparam int N  = 10;
   localparam int DW = 16;

   logic            i_clk;
   logic            i_reset;
   logic [N*DW-1:0] i_input;
   logic [N-1:0]    i_input_valid;
   logic            o_busy;
   logic [3:0]      o_max_index;
   logic [DW-1:0]   o_max_value;
   logic            o_valid;
   logic            o_overrun;

   int n_tests;
   int n_fail;

   logic [DW-1:0] frame_val [N];

   layer_argmax #(.NUM_NEURON(N), .DATA_WIDTH(DW)) dut (
      .i_clk         (i_clk),
      .i_reset       (i_reset),
      .i_input       (i_input),
      .i_input_valid (i_input_valid),
      .o_busy        (o_busy),
      .o_max_index   (o_max_index),
      .o_max_value   (o_max_value),
      .o_valid       (o_valid),
      .o_overrun     (o_overrun)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic send_all();
      for (int k = 0; k < N; k++) i_input[k*DW +: DW] = frame_val[k];
      i_input_valid = '1;
      tick();
      i_input_valid = '0;
   endtask

   // Called just after the edge that completed collection; cycle 1 is sampled immediately.
   task automatic watch_frame(input string tag, input int inj_k,
                              input logic [3:0] exp_idx, input logic [DW-1:0] exp_val);
      int busy_cnt;
      int valid_cnt;
      int valid_at;
      int ovr_cnt;
      logic [3:0]    got_idx;
      logic [DW-1:0] got_val;
      busy_cnt  = 0;
      valid_cnt = 0;
      valid_at  = 0;
      ovr_cnt   = 0;
      got_idx   = '0;
      got_val   = '0;
      for (int k = 1; k <= 20; k++) begin
         if (o_busy) busy_cnt++;
         if (o_overrun) ovr_cnt++;
         if (o_valid) begin
            valid_cnt++;
            if (valid_cnt == 1) begin
               valid_at = k;
               got_idx  = o_max_index;
               got_val  = o_max_value;
            end
         end
         if (k == inj_k) begin
            i_input[4*DW +: DW] = 16'h7FFF;
            i_input_valid       = 10'b00_0001_0000;
         end
         tick();
         i_input_valid = '0;
      end
      check({tag, "_valid_count"}, valid_cnt, 1);
      check({tag, "_latency"}, valid_at, N);
      check({tag, "_busy_cycles"}, busy_cnt, N);
      check({tag, "_index"}, got_idx, exp_idx);
      check({tag, "_value"}, got_val, exp_val);
      check({tag, "_overrun"}, ovr_cnt, (inj_k > 0) ? 1 : 0);
      check({tag, "_hold_index"}, o_max_index, exp_idx);
   endtask

   initial begin
      int vcnt;
      n_tests       = 0;
      n_fail        = 0;
      i_reset       = 1'b1;
      i_input       = '0;
      i_input_valid = '0;
      tick();
      tick();
      i_reset = 1'b0;

      check("rst_busy", o_busy, 0);
      check("rst_valid", o_valid, 0);
      check("rst_index", o_max_index, 0);
      check("rst_value", o_max_value, 0);
      check("rst_overrun", o_overrun, 0);

      // 1: all lanes in one cycle, lane 7 is the peak
      for (int k = 0; k < N; k++) frame_val[k] = DW'(k * 16'h0100);
      frame_val[7] = 16'h7FFF;
      send_all();
      watch_frame("t1", 0, 4'd7, 16'h7FFF);

      // 2: one lane per cycle, 9 down to 0
      for (int k = 0; k < N; k++) frame_val[k] = DW'(k * 16'h0080);
      frame_val[3] = 16'h0A00;
      for (int k = N - 1; k >= 0; k--) begin
         i_input[k*DW +: DW] = frame_val[k];
         i_input_valid       = N'(1) << k;
         tick();
         i_input_valid = '0;
         if (k != 0) check("t2_collect_busy", o_busy, 0);
      end
      watch_frame("t2", 0, 4'd3, 16'h0A00);

      // 3: tie between lanes 2 and 5
      for (int k = 0; k < N; k++) frame_val[k] = 16'h0100;
      frame_val[2] = 16'h1234;
      frame_val[5] = 16'h1234;
      send_all();
      watch_frame("t3", 0, 4'd2, 16'h1234);

      // 4: all negative, -1 is largest
      for (int k = 0; k < N; k++) frame_val[k] = 16'h8000;
      frame_val[9] = 16'hFFFF;
      send_all();
      watch_frame("t4", 0, 4'd9, 16'hFFFF);

      // 5: reset during SCAN cycle 4 aborts the frame
      for (int k = 0; k < N; k++) frame_val[k] = DW'(k * 16'h0100);
      frame_val[8] = 16'h6000;
      send_all();
      tick();
      tick();
      tick();
      i_reset = 1'b1;
      tick();
      i_reset = 1'b0;
      check("t5_rst_busy", o_busy, 0);
      check("t5_rst_valid", o_valid, 0);
      check("t5_rst_index", o_max_index, 0);
      check("t5_rst_value", o_max_value, 0);
      check("t5_rst_overrun", o_overrun, 0);
      vcnt = 0;
      for (int k = 0; k < 15; k++) begin
         if (o_valid || o_busy) vcnt++;
         tick();
      end
      check("t5_no_valid_after_abort", vcnt, 0);
      for (int k = 0; k < N; k++) frame_val[k] = DW'(k * 16'h0100);
      frame_val[0] = 16'h4000;
      send_all();
      watch_frame("t5b", 0, 4'd0, 16'h4000);

      // 6: stray lane 4 pulse mid-scan is dropped
      for (int k = 0; k < N; k++) frame_val[k] = 16'h0100;
      frame_val[1] = 16'h2000;
      send_all();
      watch_frame("t6", 3, 4'd1, 16'h2000);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
